// File: rtl/eth_rx_udp_frame_controller_if.sv
// AXI-Stream beat bundle without tready, used for the MAC RX input and the realigned payload output.
interface eth_rx_udp_frame_controller_if;
    logic        tvalid;
    logic [63:0] tdata;
    logic        tlast;
    logic [7:0]  tkeep;

    modport master (output tvalid, tdata, tlast, tkeep);
    modport slave  (input  tvalid, tdata, tlast, tkeep);
endinterface

// File: rtl/eth_rx_udp_frame_controller.sv
// 10G RX sequencer: captures the Ethernet/IPv4/UDP header, filters on local MAC/IP and realigns the
// accepted payload from lane 2 to lane 0. Defining ETH_RX_FRAME_STATS_EN adds saturating frame counters.
module eth_rx_udp_frame_controller (
    input  logic                                 i_clk,
    input  logic                                 i_reset_n,
    input  logic [47:0]                          i_local_mac,
    input  logic [31:0]                          i_local_ip,
    eth_rx_udp_frame_controller_if.slave         rx_axis,
    eth_rx_udp_frame_controller_if.master        pl,
    output logic                                 o_hdr_valid,
    output logic [47:0]                          o_dst_mac,
    output logic [47:0]                          o_src_mac,
    output logic [31:0]                          o_src_ip,
    output logic [31:0]                          o_dst_ip,
    output logic [15:0]                          o_udp_src_port,
    output logic [15:0]                          o_udp_dst_port,
    output logic [15:0]                          o_udp_length,
    output logic                                 o_drop,
    output logic [1:0]                           o_drop_reason
`ifdef ETH_RX_FRAME_STATS_EN
    ,
    output logic [31:0]                          o_frames_accepted,
    output logic [31:0]                          o_frames_dropped
`endif
);

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, FLUSH, DROP} state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [3:0]   flush_c_q, flush_c_d;
    logic [319:0] hdr_q;
    logic [47:0]  hold_q;

    logic         hdr_wr, hold_wr;
    logic [2:0]   hdr_idx;
    logic         accept_d, drop_d;
    logic [1:0]   reason_d;
    logic         pl_vld_d, pl_last_d;
    logic [63:0]  pl_data_d;
    logic [7:0]   pl_keep_d;
    logic [3:0]   keep_cnt;

    logic [47:0]  f_dst_mac, f_src_mac;
    logic [31:0]  f_src_ip, f_dst_ip;
    logic [15:0]  f_ethertype, f_sport, f_dport, f_ulen;
    logic         mac_ok, proto_ok, ip_ok;
    logic         hdr_unused;

    function automatic logic [3:0] popcnt8(input logic [7:0] k);
        logic [3:0] n;
        n = '0;
        for (int j = 0; j < 8; j++) n = n + {3'b000, k[j]};
        return n;
    endfunction

    function automatic logic [63:0] keep_mask(input logic [7:0] k);
        logic [63:0] m;
        for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{k[j]}};
        return m;
    endfunction

    // Gathers n header bytes starting at 'first', first byte ending up most significant.
    function automatic logic [47:0] be_bytes(input logic [319:0] h, input int first, input int n);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[39:0], h[8*(first+i) +: 8]};
        return r;
    endfunction

    assign f_dst_mac   = be_bytes(hdr_q, 0, 6);
    assign f_src_mac   = be_bytes(hdr_q, 6, 6);
    assign f_ethertype = 16'(be_bytes(hdr_q, 12, 2));
    assign f_src_ip    = 32'(be_bytes(hdr_q, 26, 4));
    assign f_dst_ip    = 32'(be_bytes(hdr_q, 30, 4));
    assign f_sport     = 16'(be_bytes(hdr_q, 34, 2));
    assign f_dport     = 16'(be_bytes(hdr_q, 36, 2));
    assign f_ulen      = 16'(be_bytes(hdr_q, 38, 2));
    assign hdr_unused  = ^{hdr_q[183:120], hdr_q[207:192]};

    assign mac_ok   = (f_dst_mac == i_local_mac) || (f_dst_mac == 48'hFFFF_FFFF_FFFF);
    assign proto_ok = (f_ethertype == 16'h0800) && (hdr_q[119:112] == 8'h45) && (hdr_q[191:184] == 8'h11);
    assign ip_ok    = (f_dst_ip == i_local_ip);
    assign keep_cnt = popcnt8(rx_axis.tkeep);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_c_d = flush_c_q;
        hdr_wr    = 1'b0;
        hdr_idx   = 3'd0;
        hold_wr   = 1'b0;
        accept_d  = 1'b0;
        drop_d    = 1'b0;
        reason_d  = 2'd0;
        pl_vld_d  = 1'b0;
        pl_data_d = '0;
        pl_keep_d = '0;
        pl_last_d = 1'b0;

        case (state_q)
            IDLE, FLUSH: begin
                if (state_q == FLUSH) begin
                    pl_vld_d  = 1'b1;
                    pl_data_d = {16'h0000, hold_q};
                    pl_keep_d = (8'h01 << (flush_c_q - 4'd2)) - 8'h01;
                    pl_last_d = 1'b1;
                    state_d   = IDLE;
                end
                // A beat here is always beat 0 of a new frame, even in the flush cycle.
                if (rx_axis.tvalid) begin
                    hdr_wr  = 1'b1;
                    hdr_idx = 3'd0;
                    if (rx_axis.tlast) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = HEADER;
                        cnt_d   = 3'd1;
                    end
                end
            end
            HEADER: begin
                if (rx_axis.tvalid) begin
                    if (cnt_q != 3'd5) begin
                        hdr_wr  = 1'b1;
                        hdr_idx = cnt_q;
                        if (rx_axis.tlast) begin
                            drop_d  = 1'b1;
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_d = 3'd0;
                        if (mac_ok && proto_ok && ip_ok) begin
                            accept_d = 1'b1;
                            hold_wr  = 1'b1;
                            if (!rx_axis.tlast) begin
                                state_d = PAYLOAD;
                            end else if (keep_cnt > 4'd2) begin
                                state_d   = FLUSH;
                                flush_c_d = keep_cnt;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            drop_d   = 1'b1;
                            reason_d = !mac_ok ? 2'd1 : (!proto_ok ? 2'd2 : 2'd3);
                            state_d  = rx_axis.tlast ? IDLE : DROP;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (rx_axis.tvalid) begin
                    hold_wr   = 1'b1;
                    pl_vld_d  = 1'b1;
                    pl_data_d = {rx_axis.tdata[15:0], hold_q};
                    pl_keep_d = 8'hFF;
                    if (rx_axis.tlast) begin
                        if (keep_cnt <= 4'd2) begin
                            pl_keep_d = (8'h01 << (keep_cnt + 4'd6)) - 8'h01;
                            pl_last_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            state_d   = FLUSH;
                            flush_c_d = keep_cnt;
                        end
                    end
                end
            end
            DROP: begin
                if (rx_axis.tvalid && rx_axis.tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pl_data_d = pl_data_d & keep_mask(pl_keep_d);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            flush_c_q      <= '0;
            o_hdr_valid    <= 1'b0;
            o_dst_mac      <= '0;
            o_src_mac      <= '0;
            o_src_ip       <= '0;
            o_dst_ip       <= '0;
            o_udp_src_port <= '0;
            o_udp_dst_port <= '0;
            o_udp_length   <= '0;
            o_drop         <= 1'b0;
            o_drop_reason  <= '0;
            pl.tvalid      <= 1'b0;
            pl.tdata       <= '0;
            pl.tlast       <= 1'b0;
            pl.tkeep       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flush_c_q     <= flush_c_d;
            o_hdr_valid   <= accept_d;
            if (accept_d) begin
                o_dst_mac      <= f_dst_mac;
                o_src_mac      <= f_src_mac;
                o_src_ip       <= f_src_ip;
                o_dst_ip       <= f_dst_ip;
                o_udp_src_port <= f_sport;
                o_udp_dst_port <= f_dport;
                o_udp_length   <= f_ulen;
            end
            o_drop        <= drop_d;
            o_drop_reason <= reason_d;
            pl.tvalid     <= pl_vld_d;
            pl.tdata      <= pl_data_d;
            pl.tlast      <= pl_last_d;
            pl.tkeep      <= pl_keep_d;
        end
    end

    // Header beats and the lane 2-7 carry are pure data; the FSM decides when they are meaningful.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 5; b++) begin
            if (hdr_wr && (hdr_idx == 3'(b))) hdr_q[64*b +: 64] <= rx_axis.tdata;
        end
        if (hold_wr) hold_q <= rx_axis.tdata[63:16];
    end

`ifdef ETH_RX_FRAME_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_frames_accepted <= '0;
            o_frames_dropped  <= '0;
        end else begin
            if (accept_d) o_frames_accepted <= sat_inc(o_frames_accepted);
            if (drop_d)   o_frames_dropped  <= sat_inc(o_frames_dropped);
        end
    end
`else
    // Without statistics the accept/drop pulses are the only per-frame indication.
`endif

endmodule

// File: tb/tb_eth_rx_udp_frame_controller.sv
// Directed + randomized bench for eth_rx_udp_frame_controller with a byte-level frame reference model.
module tb_eth_rx_udp_frame_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic        hdr_valid, drop;
    logic [47:0] dst_mac, src_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] udp_sp, udp_dp, udp_len;
    logic [1:0]  drop_reason;
`ifdef ETH_RX_FRAME_STATS_EN
    logic [31:0] frames_acc, frames_drp;
`endif

    eth_rx_udp_frame_controller_if rx_if ();
    eth_rx_udp_frame_controller_if pl_if ();

    eth_rx_udp_frame_controller dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_local_mac    (local_mac),
        .i_local_ip     (local_ip),
        .rx_axis        (rx_if),
        .pl             (pl_if),
        .o_hdr_valid    (hdr_valid),
        .o_dst_mac      (dst_mac),
        .o_src_mac      (src_mac),
        .o_src_ip       (src_ip),
        .o_dst_ip       (dst_ip),
        .o_udp_src_port (udp_sp),
        .o_udp_dst_port (udp_dp),
        .o_udp_length   (udp_len),
        .o_drop         (drop),
        .o_drop_reason  (drop_reason)
`ifdef ETH_RX_FRAME_STATS_EN
        ,
        .o_frames_accepted (frames_acc),
        .o_frames_dropped  (frames_drp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_drop;
        logic [1:0]  reason;
        logic [47:0] dmac, smac;
        logic [31:0] sip, dip;
        logic [15:0] sp, dp, ul;
    } evt_t;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    evt_t  exp_e[$], act_e[$];
    beat_t exp_b[$], act_b[$];

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         idle_bad = 0;
    logic [7:0] fr [0:255];
    int         fr_len;
    int         bcyc [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output event with the cycle it was observed in.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            evt_t  e;
            beat_t b;
            e = '{default: 0};
            if (hdr_valid === 1'b1) begin
                e.cyc = cyc; e.is_drop = 1'b0; e.reason = 2'd0;
                e.dmac = dst_mac; e.smac = src_mac; e.sip = src_ip; e.dip = dst_ip;
                e.sp = udp_sp; e.dp = udp_dp; e.ul = udp_len;
                act_e.push_back(e);
            end
            if (drop === 1'b1) begin
                e = '{default: 0};
                e.cyc = cyc; e.is_drop = 1'b1; e.reason = drop_reason;
                act_e.push_back(e);
            end
            if (pl_if.tvalid === 1'b1) begin
                b.cyc = cyc; b.data = pl_if.tdata; b.keep = pl_if.tkeep; b.last = pl_if.tlast;
                act_b.push_back(b);
            end else if (pl_if.tdata !== 64'h0 || pl_if.tkeep !== 8'h0 || pl_if.tlast !== 1'b0) begin
                idle_bad++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        chk({pfx, "_pl_tvalid"}, pl_if.tvalid, 0);
        chk({pfx, "_pl_tdata"}, pl_if.tdata, 0);
        chk({pfx, "_pl_tlast"}, pl_if.tlast, 0);
        chk({pfx, "_pl_tkeep"}, pl_if.tkeep, 0);
        chk({pfx, "_hdr_valid"}, hdr_valid, 0);
        chk({pfx, "_drop"}, drop, 0);
        chk({pfx, "_drop_reason"}, drop_reason, 0);
        chk({pfx, "_dst_mac"}, dst_mac, 0);
        chk({pfx, "_dst_ip"}, dst_ip, 0);
        chk({pfx, "_udp_length"}, udp_len, 0);
    endtask

    // kind: 0 unicast ok, 1 broadcast ok, 2 bad MAC, 3 bad ethertype, 4 bad IHL byte,
    //       5 not UDP, 6 bad dst IP, 7 bad MAC and bad ethertype
    task automatic build_frame(input int len, input int kind);
        logic [47:0] dmac;
        logic [15:0] et;
        logic [31:0] dip;
        fr_len = len;
        for (int i = 0; i < 256; i++) fr[i] = 8'($urandom);
        dmac = (kind == 1) ? 48'hFFFF_FFFF_FFFF :
               (kind == 2 || kind == 7) ? (local_mac ^ {40'h0, 8'($urandom_range(255, 1))}) : local_mac;
        et   = (kind == 3 || kind == 7) ? 16'h86DD : 16'h0800;
        dip  = (kind == 6) ? (local_ip ^ 32'h0000_0001) : local_ip;
        for (int i = 0; i < 6; i++) fr[i] = dmac[47-8*i -: 8];
        fr[12] = et[15:8];
        fr[13] = et[7:0];
        fr[14] = (kind == 4) ? 8'h46 : 8'h45;
        fr[23] = (kind == 5) ? 8'h06 : 8'h11;
        for (int i = 0; i < 4; i++) fr[30+i] = dip[31-8*i -: 8];
    endtask

    // Drives fr[0..fr_len-1]; abort_beat >= 0 pulls reset while that beat is on the bus.
    task automatic send_frame(input int gap_max, input int abort_beat);
        int nb;
        int g;
        int cnt;
        nb = (fr_len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            g = (b == 0) ? 0 : $urandom_range(gap_max, 0);
            repeat (g) begin
                rx_if.tvalid = 1'b0;
                rx_if.tlast  = 1'b0;
                @(negedge clk);
            end
            cnt = (fr_len - 8*b >= 8) ? 8 : fr_len - 8*b;
            for (int j = 0; j < 8; j++)
                rx_if.tdata[8*j +: 8] = (j < cnt) ? fr[8*b+j] : 8'($urandom);
            rx_if.tkeep  = 8'((1 << cnt) - 1);
            rx_if.tlast  = (b == nb - 1);
            rx_if.tvalid = 1'b1;
            bcyc[b] = cyc + 1;
            if (b == abort_beat) begin
                #2 rst_n = 1'b0;
                #1 check_outputs_zero("midrst");
                @(negedge clk);
                rx_if.tvalid = 1'b0;
                rx_if.tlast  = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
        rx_if.tkeep  = 8'h00;
        rx_if.tdata  = 64'h0;
    endtask

    // Expected outcome of the frame in fr[]; max_beats >= 0 limits the payload beats expected.
    task automatic push_expected(input int max_beats);
        evt_t        e;
        beat_t       bt;
        int          nb, n, cnt, src;
        logic [47:0] dmac;
        logic [15:0] et;
        logic [31:0] dip;
        e  = '{default: 0};
        nb = (fr_len + 7) / 8;
        if (fr_len <= 40) begin
            e.cyc = bcyc[nb-1]; e.is_drop = 1'b1; e.reason = 2'd0;
            exp_e.push_back(e);
            return;
        end
        dmac  = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
        et    = {fr[12], fr[13]};
        dip   = {fr[30], fr[31], fr[32], fr[33]};
        e.cyc = bcyc[5];
        if (dmac !== local_mac && dmac !== 48'hFFFF_FFFF_FFFF) begin
            e.is_drop = 1'b1; e.reason = 2'd1;
        end else if (et !== 16'h0800 || fr[14] !== 8'h45 || fr[23] !== 8'h11) begin
            e.is_drop = 1'b1; e.reason = 2'd2;
        end else if (dip !== local_ip) begin
            e.is_drop = 1'b1; e.reason = 2'd3;
        end
        if (e.is_drop) begin
            exp_e.push_back(e);
            return;
        end
        e.dmac = dmac;
        e.smac = {fr[6], fr[7], fr[8], fr[9], fr[10], fr[11]};
        e.sip  = {fr[26], fr[27], fr[28], fr[29]};
        e.dip  = dip;
        e.sp   = {fr[34], fr[35]};
        e.dp   = {fr[36], fr[37]};
        e.ul   = {fr[38], fr[39]};
        exp_e.push_back(e);
        n = fr_len - 42;
        for (int k = 0; 8*k < n; k++) begin
            if (max_beats >= 0 && k >= max_beats) break;
            cnt = (n - 8*k >= 8) ? 8 : n - 8*k;
            bt.data = 64'h0;
            for (int j = 0; j < cnt; j++) bt.data[8*j +: 8] = fr[42 + 8*k + j];
            bt.keep = 8'((1 << cnt) - 1);
            bt.last = (8*k + 8 >= n);
            src     = 6 + k;
            bt.cyc  = (src <= nb - 1) ? bcyc[src] : bcyc[nb-1] + 1;
            exp_b.push_back(bt);
        end
    endtask

    task automatic run_frame(input int len, input int kind, input int gap_max, input int idle_after);
        build_frame(len, kind);
        send_frame(gap_max, -1);
        push_expected(-1);
        repeat (idle_after) @(negedge clk);
    endtask

    initial begin
        int nev, nbt;
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
        rx_if.tkeep  = 8'h00;
        rx_if.tdata  = 64'h0;
        local_mac    = {8'h02, 32'($urandom), 8'($urandom)};
        local_ip     = 32'($urandom);

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(92, 0, 0, 3);
        run_frame(104, 1, 0, 3);
        run_frame(106, 1, 0, 3);
        run_frame(80, 6, 0, 0);
        run_frame(70, 0, 0, 3);
        run_frame(30, 0, 0, 0);
        run_frame(60, 0, 0, 2);
        run_frame(80, 3, 0, 1);
        run_frame(80, 7, 0, 1);
        run_frame(80, 2, 0, 1);
        run_frame(64, 4, 1, 0);
        run_frame(64, 5, 1, 0);
        run_frame(41, 0, 0, 0);
        run_frame(42, 0, 0, 0);
        run_frame(43, 1, 0, 0);
        run_frame(48, 0, 0, 0);
        run_frame(49, 0, 1, 0);
        run_frame(50, 0, 0, 0);
        run_frame(8, 0, 0, 0);
        run_frame(40, 0, 0, 2);

        for (int f = 0; f < 60; f++)
            run_frame($urandom_range(150, 20), $urandom_range(7, 0), 2, $urandom_range(2, 0));
        repeat (4) @(negedge clk);

        build_frame(120, 0);
        send_frame(0, 7);
        push_expected(1);
        repeat (3) @(negedge clk);
        run_frame(92, 0, 0, 6);

        chk("event_count", act_e.size(), exp_e.size());
        chk("beat_count", act_b.size(), exp_b.size());
        nev = (act_e.size() < exp_e.size()) ? act_e.size() : exp_e.size();
        nbt = (act_b.size() < exp_b.size()) ? act_b.size() : exp_b.size();
        for (int i = 0; i < nev; i++) begin
            chk($sformatf("evt%0d_cycle", i), act_e[i].cyc, exp_e[i].cyc);
            chk($sformatf("evt%0d_is_drop", i), act_e[i].is_drop, exp_e[i].is_drop);
            chk($sformatf("evt%0d_reason", i), act_e[i].reason, exp_e[i].reason);
            if (!exp_e[i].is_drop) begin
                chk($sformatf("evt%0d_dst_mac", i), act_e[i].dmac, exp_e[i].dmac);
                chk($sformatf("evt%0d_src_mac", i), act_e[i].smac, exp_e[i].smac);
                chk($sformatf("evt%0d_src_ip", i), act_e[i].sip, exp_e[i].sip);
                chk($sformatf("evt%0d_dst_ip", i), act_e[i].dip, exp_e[i].dip);
                chk($sformatf("evt%0d_src_port", i), act_e[i].sp, exp_e[i].sp);
                chk($sformatf("evt%0d_dst_port", i), act_e[i].dp, exp_e[i].dp);
                chk($sformatf("evt%0d_udp_len", i), act_e[i].ul, exp_e[i].ul);
            end
        end
        for (int i = 0; i < nbt; i++) begin
            chk($sformatf("beat%0d_cycle", i), act_b[i].cyc, exp_b[i].cyc);
            chk($sformatf("beat%0d_data", i), act_b[i].data, exp_b[i].data);
            chk($sformatf("beat%0d_keep", i), act_b[i].keep, exp_b[i].keep);
            chk($sformatf("beat%0d_last", i), act_b[i].last, exp_b[i].last);
        end
        chk("idle_payload_zero", idle_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
